// File: rtl/adder_sequencer_pkg.sv
// Shared definitions for the sequencer blocks.
//   seq_state_t   : FSM state encoding (IDLE/ADD/DONE)
//   DEFAULT_WIDTH : default operand width in bits
package adder_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADD  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational 2-bit ripple adder with carry-in.
//   A, B : 2-bit addends
//   Cin  : carry in
//   S    : 2-bit sum
//   Cout : carry out of bit 1
module adder_slice (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin,
    output logic [1:0] S,
    output logic       Cout
);

    logic c_mid;

    always_comb begin
        S[0]  = A[0] ^ B[0] ^ Cin;
        c_mid = (A[0] & B[0]) | (Cin & (A[0] ^ B[0]));
        S[1]  = A[1] ^ B[1] ^ c_mid;
        Cout  = (A[1] & B[1]) | (c_mid & (A[1] ^ B[1]));
    end

endmodule

// File: rtl/adder_sequencer.sv
// Multi-cycle adder: adds two latched WIDTH-bit operands one 2-bit slice
// per clock, LSB slice first, through a single shared adder_slice.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for Start; result registers hold
//   ADD     | one slice per cycle, idx = slice being added
//   DONE    | result valid, Done pulses for this one cycle
//
// Ports:
//   Clk       : clock, rising edge
//   Rst       : synchronous active-high reset
//   Start     : request an add of A and B (sampled only in IDLE)
//   A, B      : operands, latched when Start is accepted
//   Busy      : high in ADD and DONE
//   Done      : one-cycle result-valid pulse
//   Sum_reg   : registered sum (modulo 2^WIDTH)
//   Carry_reg : registered carry-out of the MSB slice
module adder_sequencer
    import adder_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum_reg,
    output logic             Carry_reg
);

    localparam int SLICES = WIDTH / 2;
    // keep idx at least one bit wide so WIDTH=2 still elaborates
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;

    logic [1:0]       slice_a, slice_b, slice_s;
    logic             slice_cout;
    logic             last_slice;

    assign last_slice = (idx_q == LAST_IDX);
    assign slice_a    = op_a_q[{idx_q, 1'b0} +: 2];
    assign slice_b    = op_b_q[{idx_q, 1'b0} +: 2];

    adder_slice u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q),
        .S    (slice_s),
        .Cout (slice_cout)
    );

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start)      state_d = ST_ADD;
            ST_ADD:  if (last_slice) state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the state register only, so no input reaches them combinationally.
    assign Busy = (state_q == ST_ADD) || (state_q == ST_DONE);
    assign Done = (state_q == ST_DONE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            Sum_reg   <= '0;
            Carry_reg <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        op_a_q    <= A;
                        op_b_q    <= B;
                        idx_q     <= '0;
                        carry_q   <= 1'b0;
                        Sum_reg   <= '0;
                        Carry_reg <= 1'b0;
                    end
                end
                ST_ADD: begin
                    Sum_reg[{idx_q, 1'b0} +: 2] <= slice_s;
                    carry_q <= slice_cout;
                    if (last_slice) begin
                        Carry_reg <= slice_cout;
                        idx_q     <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sequencer.sv
module tb_adder_sequencer;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic [7:0] A, B;
    logic       Busy, Done;
    logic [7:0] Sum_reg;
    logic       Carry_reg;

    int total = 0;
    int bad   = 0;

    adder_sequencer #(.WIDTH(8)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Sum_reg   (Sum_reg),
        .Carry_reg (Carry_reg)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge; drive and sample 1 time unit after it
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        A     = a;
        B     = b;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!Done && n < 10) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, 32'(Done), 32'd1);
    endtask

    initial begin
        int dones;
        int last_done;
        logic [7:0] ra, rb;

        Rst = 1'b1; Start = 1'b0; A = '0; B = '0;
        step(); step();
        Rst = 1'b0;

        check("rst_busy",  32'(Busy),      32'd0);
        check("rst_done",  32'(Done),      32'd0);
        check("rst_sum",   32'(Sum_reg),   32'd0);
        check("rst_carry", 32'(Carry_reg), 32'd0);

        // 0F + 01: exact latency
        start_op(8'h0F, 8'h01);                 // edge 0
        check("lat_busy_e0", 32'(Busy), 32'd1);
        check("lat_done_e0", 32'(Done), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("lat_done_early", 32'(Done), 32'd0);
            check("lat_busy_mid",   32'(Busy), 32'd1);
        end
        step();                                 // edge 4
        check("lat_done_e4",  32'(Done),      32'd1);
        check("lat_busy_e4",  32'(Busy),      32'd1);
        check("lat_sum",      32'(Sum_reg),   32'h10);
        check("lat_carry",    32'(Carry_reg), 32'd0);
        step();                                 // edge 5
        check("lat_busy_e5",  32'(Busy),      32'd0);
        check("lat_done_e5",  32'(Done),      32'd0);
        check("lat_sum_hold", 32'(Sum_reg),   32'h10);

        // FF + 01: carry ripples through every slice
        start_op(8'hFF, 8'h01);
        wait_done("ovf");
        check("ovf_sum",   32'(Sum_reg),   32'h00);
        check("ovf_carry", 32'(Carry_reg), 32'd1);
        step();

        // 3C + A5 with operands changed mid-operation; Start in DONE ignored
        start_op(8'h3C, 8'hA5);
        A = 8'h00; B = 8'h00;
        wait_done("chg");
        check("chg_sum",   32'(Sum_reg),   32'hE1);
        check("chg_carry", 32'(Carry_reg), 32'd0);
        A = 8'h01; B = 8'h01; Start = 1'b1;
        step();
        Start = 1'b0;
        check("done_start_ignored", 32'(Busy),    32'd0);
        step();
        check("done_start_idle",    32'(Busy),    32'd0);
        check("done_start_hold",    32'(Sum_reg), 32'hE1);

        // reset at edge 2 of an operation
        start_op(8'h12, 8'h34);                 // edge 0
        step();                                 // edge 1
        Rst = 1'b1;
        step();                                 // edge 2
        Rst = 1'b0;
        check("mid_rst_busy",  32'(Busy),      32'd0);
        check("mid_rst_done",  32'(Done),      32'd0);
        check("mid_rst_sum",   32'(Sum_reg),   32'd0);
        check("mid_rst_carry", 32'(Carry_reg), 32'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Done) dones++;
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);

        // Start coincident with Rst is dropped
        A = 8'h55; B = 8'h55; Start = 1'b1; Rst = 1'b1;
        step();
        Start = 1'b0; Rst = 1'b0;
        check("rst_start_busy",  32'(Busy), 32'd0);
        step();
        check("rst_start_busy2", 32'(Busy), 32'd0);

        start_op(8'h01, 8'h01);
        wait_done("post_rst");
        check("post_rst_sum",   32'(Sum_reg),   32'h02);
        check("post_rst_carry", 32'(Carry_reg), 32'd0);
        step();

        // Start held high: one Done every 6 cycles, first at edge 4
        A = 8'h11; B = 8'h22; Start = 1'b1;
        dones = 0;
        last_done = -2;
        for (int e = 0; e < 36; e++) begin
            step();
            if (Done) begin
                dones++;
                check("held_done_spacing", 32'(e - last_done), (dones == 1) ? 32'd6 : 32'd6);
                check("held_sum", 32'(Sum_reg), 32'h33);
                last_done = e;
            end
        end
        Start = 1'b0;
        check("held_done_count", 32'(dones), 32'd6);
        for (int i = 0; i < 8 && Busy; i++) step();
        check("held_idle", 32'(Busy), 32'd0);

        // random operands against a reference sum
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            start_op(ra, rb);
            A = 8'($urandom);
            B = 8'($urandom);
            wait_done("rnd");
            check("rnd_sum", 32'({Carry_reg, Sum_reg}), 32'({1'b0, ra} + {1'b0, rb}));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
